// File: rtl/ex_mdu_stage.sv
// ex_mdu_stage: iterative RISC-V M-extension unit for the EX stage.
// Multiplies by shift-add and divides by restoring division, one radix-2
// step per cycle, on operand magnitudes with a sign fix-up at the end.
// Divide-by-zero, signed overflow and illegal word-high multiplies finish
// in a single cycle. hold_req_o stalls the pipeline while the unit works.
module ex_mdu_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic                  word_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_idx_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  hold_req_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_idx_o,
  output logic                  reg_wr_en_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam bit WORD_OK = (XLEN == 64);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Replace bits above 31 with bit 31 (sgn=1) or zero (sgn=0).
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
    return r;
  endfunction

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + ONE_X) : v;
  endfunction

  // Word results are the low 32 bits sign-extended to XLEN.
  function automatic logic [XLEN-1:0] word_fmt(input logic [XLEN-1:0] v, input logic word);
    return word ? ext32(v, 1'b1) : v;
  endfunction

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;

  // Captured operation and datapath registers (no reset needed)
  logic [2:0]            op_q;
  logic                  word_q;
  logic                  neg_q;
  logic                  rneg_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [2*XLEN-1:0]     mcand_q;
  logic [XLEN-1:0]       mplier_q;

  // Start decode
  logic                  word_eff, is_div, a_sgn, b_sgn;
  logic [XLEN-1:0]       a_val, b_val, a_mag, b_mag, min_val, dvd;
  logic                  a_neg, b_neg;
  logic                  illegal, div_zero, ovf, special, accept;
  logic [XLEN-1:0]       spec_res;
  logic [CNT_W-1:0]      n_load;

  // Iteration step
  logic [XLEN:0]         hi, diff;
  logic [2*XLEN-1:0]     acc_nx, mcand_nx, prod;
  logic [XLEN-1:0]       mplier_nx, raw_res, calc_res;

  assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

  // Operand conditioning and special-case detection for a new instruction
  always_comb begin
    word_eff = word_i & WORD_OK;
    is_div   = op_i[2];
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_i[0] : ~op_i[1];
    a_val    = word_eff ? ext32(rs1_i, a_sgn) : rs1_i;
    b_val    = word_eff ? ext32(rs2_i, b_sgn) : rs2_i;
    a_neg    = a_sgn & a_val[XLEN-1];
    b_neg    = b_sgn & b_val[XLEN-1];
    a_mag    = cond_neg(a_val, a_neg);
    b_mag    = cond_neg(b_val, b_neg);
    dvd      = word_eff ? (a_mag << (XLEN - 32)) : a_mag;
    min_val  = word_eff ? ext32(MOST_NEG >> (XLEN - 32), 1'b1) : MOST_NEG;
    illegal  = word_eff & ~is_div & (op_i[1:0] != 2'b00);
    div_zero = is_div & (b_val == '0);
    ovf      = is_div & ~op_i[0] & (a_val == min_val) & (b_val == '1);
    special  = illegal | div_zero | ovf;
    spec_res = '0;
    if (div_zero)  spec_res = op_i[1] ? a_val : '1;
    else if (ovf)  spec_res = op_i[1] ? '0 : a_val;
    spec_res = illegal ? '0 : word_fmt(spec_res, word_eff);
    n_load   = word_eff ? CNT_W'(32) : CNT_W'(XLEN);
  end

  // One shift-add or restoring-divide step plus the final sign fix-up
  always_comb begin
    hi        = acc_q[2*XLEN-1:XLEN-1];
    diff      = hi - {1'b0, mcand_q[XLEN-1:0]};
    acc_nx    = acc_q;
    mcand_nx  = mcand_q;
    mplier_nx = mplier_q;
    if (op_q[2]) begin
      if (!diff[XLEN]) acc_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_nx = {hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_nx  = {mcand_q[2*XLEN-2:0], 1'b0};
      mplier_nx = mplier_q >> 1;
    end
    prod = neg_q ? ((~acc_nx) + ONE_2X) : acc_nx;
    if (op_q[2])
      raw_res = op_q[1] ? cond_neg(acc_nx[2*XLEN-1:XLEN], rneg_q)
                        : cond_neg(acc_nx[XLEN-1:0], neg_q);
    else
      raw_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    calc_res = word_fmt(raw_res, word_q);
  end

  // Datapath: load magnitudes on accept, iterate while calculating
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op_i;
      word_q   <= word_eff;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      mplier_q <= b_mag;
      if (is_div) begin
        acc_q   <= {{XLEN{1'b0}}, dvd};
        mcand_q <= {{XLEN{1'b0}}, b_mag};
      end else begin
        acc_q   <= '0;
        mcand_q <= {{XLEN{1'b0}}, a_mag};
      end
    end else if (state_q == S_CALC) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_nx;
      mplier_q <= mplier_nx;
    end
  end

  // Control FSM with registered result and destination index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_o <= '0;
      rd_idx_o <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rd_idx_o <= rd_idx_i;
            if (special) begin
              result_o <= spec_res;
              state_q  <= S_DONE;
            end else begin
              cnt_q   <= n_load;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_q == CNT_W'(1)) begin
            result_o <= calc_res;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A flush in the done cycle kills the write-back as well
  assign busy_o      = (state_q == S_CALC);
  assign done_o      = (state_q == S_DONE) & ~flush_i;
  assign reg_wr_en_o = done_o;
  assign hold_req_o  = rst_n & (accept | (state_q == S_CALC));

endmodule

// File: doc/ex_mdu_stage.md
Name: ex_mdu_stage

Overview:
- Parametrised execute-stage extension: an iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the word forms) with a start/busy/done handshake.
- Sits beside the single-cycle ALU in the EX stage and raises a hold request to pipeline control while it computes.
- Returns its result with the destination register index, so the EX/MEM register captures it in the done cycle.
- Supports XLEN-wide and 32-bit word mode, pipeline flush, and fast paths for divide special cases.

Parameters:
- XLEN, 64, datapath width (32 or 64); word mode is legal only when XLEN=64.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  MDU instruction valid in EX
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word_i  in  1  word form (MULW/DIVW/DIVUW/REMW/REMUW)
- rs1_i  in  XLEN  operand 1
- rs2_i  in  XLEN  operand 2
- rd_idx_i  in  REG_ADDR_W  destination register
- flush_i  in  1  abort current operation
- busy_o  out  1  operation in progress (state CALC)
- hold_req_o  out  1  stall request to pipeline control
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  XLEN  result
- rd_idx_o  out  REG_ADDR_W  captured destination register
- reg_wr_en_o  out  1  equals done_o

Behaviour:
- Clock and reset: one clock; reset asynchronous and active-low. Reset forces state IDLE and all outputs to 0, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1 and flush_i=0: capture op, word, rd_idx and operands.
  - Special case: go to DONE.
  - Otherwise: go to CALC with counter = N, where N = 32 if word_i else XLEN.
- CALC: one radix-2 step per cycle; counter decrements; at counter==1 go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE (the held instruction is still present).
- Latency from the start cycle: N+1 cycles normally; 1 cycle for special cases.
- hold_req_o is combinational: 1 when (IDLE & start_i & ~flush_i) or CALC; 0 in DONE so the pipeline advances that cycle.
- start_i while CALC/DONE is ignored.
- result_o and rd_idx_o hold their value until the next accepted start.
- flush_i in any state: return to IDLE next cycle with no done_o. flush_i beats start_i when both are asserted in IDLE.
- Word mode:
  - Operands are taken from bits [31:0], sign-extended (signed ops) or zero-extended (unsigned ops) to 33 bits internally.
  - Result is bits [31:0] sign-extended to XLEN.
  - word_i with op 1–3 is illegal: 1-cycle done, result 0.
- Multiply:
  - Shift-add on operand magnitudes into a 2*XLEN accumulator; the product is negated when the operand signs differ.
  - Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
- Special cases (1-cycle):
  - Divisor zero: quotient all-ones, remainder = dividend (after word extension).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
- Counter width: clog2(XLEN)+1.

Test Plan:
- MUL rs1=7, rs2=-3, XLEN=64 -> done_o at cycle 65, result 0xFFFF_FFFF_FFFF_FFEB, reg_wr_en_o=1 that cycle, hold_req_o high cycles 0–64.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE after 65 cycles.
- DIVW rs1=0x0000_0000_8000_0000, rs2=-1 -> done at cycle 1, result 0xFFFF_FFFF_8000_0000.
- DIVU 100/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 100%0 -> 100; both done at cycle 1.
- REMW rs1=-7, rs2=2 -> result 0xFFFF_FFFF_FFFF_FFFF at cycle 33; rd_idx_o matches rd_idx_i.
- DIV started, flush_i at cycle 10 -> busy_o and hold_req_o low next cycle, no done_o; a following DIVU 20/3 -> result 6 at cycle 65.
- rst_n low mid-CALC -> all outputs 0 immediately.
